position_telemetry_tx: RTL and testbench

//   Reads the x/y/z axis position words produced by the spatial position block
//   and transmits them as one framed, checksummed serial stream, MSB first.
//   It is the transmit end of the command-module telemetry link: a single send

---
 rtl/position_telemetry_tx.sv | 157 +++++++++++++++
 tb/tb_position_telemetry_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/position_telemetry_tx.sv
// rtl/position_telemetry_tx.sv - framed, checksummed serial transmitter for x/y/z position telemetry
//
// Purpose:
//   One send request snapshots pos_x/pos_y/pos_z and their truncated sum, then
//   shifts out SYNC, X, Y, Z and the checksum MSB first as one contiguous burst,
//   followed by a one-cycle done pulse.
// Ports:
//   clk       system clock, posedge
//   rst       synchronous active-high reset
//   send      frame request, level-sampled while not busy
//   pos_x/y/z axis position words (WIDTH bits, unsigned)
//   busy      frame bits in flight
//   tx_valid  tx_bit carries a frame bit
//   tx_bit    serial data, MSB first
//   done      one-cycle pulse after the last frame bit

module ripple_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);
  // Carry out of the top bit is never formed: the sum is modulo 2^W.
  logic [W-1:0] w_c;
  assign w_c[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_fa
      assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      if (gi < W - 1) begin : g_carry
        assign w_c[gi+1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
      end
    end
  endgenerate
endmodule

module position_telemetry_tx #(
  parameter int         WIDTH = 8,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [WIDTH-1:0] pos_x,
  input  logic [WIDTH-1:0] pos_y,
  input  logic [WIDTH-1:0] pos_z,
  output logic             busy,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             done
);
  localparam int MAXW = (WIDTH > 8) ? WIDTH : 8;
  localparam int CW   = $clog2(MAXW);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_XW, S_YW, S_ZW, S_CSUM, S_DONE
  } state_t;

  state_t           r_state, w_next_state;
  logic [CW-1:0]    r_cnt, w_next_cnt;
  logic [WIDTH-1:0] r_x, r_y, r_z, r_chk;
  logic             r_busy, r_tx_valid, r_tx_bit, r_done;
  logic             w_load;
  logic             w_next_busy, w_next_bit;
  logic [WIDTH-1:0] w_sum_xy, w_sum;

  ripple_adder #(.W(WIDTH)) u_add_xy  (.i_a(pos_x),    .i_b(pos_y), .o_sum(w_sum_xy));
  ripple_adder #(.W(WIDTH)) u_add_xyz (.i_a(w_sum_xy), .i_b(pos_z), .o_sum(w_sum));

  // Next state and bit counter; r_cnt is the index of the bit currently on tx_bit.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (send) begin
          w_next_state = S_SYNC;
          w_next_cnt   = CW'(7);
          w_load       = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SYNC, S_XW, S_YW, S_ZW, S_CSUM: begin
        if (r_cnt == '0) begin
          w_next_cnt = CW'(WIDTH - 1);
          case (r_state)
            S_SYNC:  w_next_state = S_XW;
            S_XW:    w_next_state = S_YW;
            S_YW:    w_next_state = S_ZW;
            S_ZW:    w_next_state = S_CSUM;
            default: w_next_state = S_DONE;
          endcase
        end else begin
          w_next_cnt = r_cnt - CW'(1);
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // alongside it. Entering SYNC needs no snapshot; later words read snapshot
  // registers that were loaded at the start edge.
  always_comb begin
    w_next_busy = 1'b0;
    w_next_bit  = 1'b0;
    case (w_next_state)
      S_SYNC: begin w_next_busy = 1'b1; w_next_bit = SYNC[w_next_cnt[2:0]]; end
      S_XW:   begin w_next_busy = 1'b1; w_next_bit = r_x[w_next_cnt];       end
      S_YW:   begin w_next_busy = 1'b1; w_next_bit = r_y[w_next_cnt];       end
      S_ZW:   begin w_next_busy = 1'b1; w_next_bit = r_z[w_next_cnt];       end
      S_CSUM: begin w_next_busy = 1'b1; w_next_bit = r_chk[w_next_cnt];     end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_bit   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_busy     <= w_next_busy;
      r_tx_valid <= w_next_busy;
      r_tx_bit   <= w_next_bit;
      r_done     <= (w_next_state == S_DONE);
    end
  end

  // Snapshot is held for the whole frame so pos_* may change freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_chk <= '0;
    end else if (w_load) begin
      r_x   <= pos_x;
      r_y   <= pos_y;
      r_z   <= pos_z;
      r_chk <= w_sum;
    end
  end

  assign busy     = r_busy;
  assign tx_valid = r_tx_valid;
  assign tx_bit   = r_tx_bit;
  assign done     = r_done;
endmodule

// File: tb/tb_position_telemetry_tx.sv
// tb/tb_position_telemetry_tx.sv - directed self-checking bench for position_telemetry_tx

module tb_position_telemetry_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] pos_x = 8'h00;
  logic [7:0] pos_y = 8'h00;
  logic [7:0] pos_z = 8'h00;
  logic       busy, tx_valid, tx_bit, done;
  int         checks = 0;
  int         errors = 0;
  int         waited;
  int         seen;

  position_telemetry_tx #(.WIDTH(8), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .send(send),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .busy(busy), .tx_valid(tx_valid), .tx_bit(tx_bit), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_send();
    @(posedge clk); #1 send = 1'b1;
    @(posedge clk); #1 send = 1'b0;
  endtask

  // Waits (bounded) for the first valid bit, gathers 40 bits, then checks the
  // done cycle. Returns at the negedge inside the done cycle.
  task automatic collect(input string tag, input logic [39:0] exp, output int nwait);
    logic [39:0] f = '0;
    logic        vok = 1'b1;
    int          w = 0;
    @(negedge clk);
    while (!tx_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    nwait = w;
    chk({tag, "_start"}, {39'b0, tx_valid}, 40'd1);
    for (int i = 0; i < 40; i++) begin
      vok = vok & tx_valid & busy & ~done;
      f = {f[38:0], tx_bit};
      @(negedge clk);
    end
    chk({tag, "_contig"}, {39'b0, vok}, 40'd1);
    chk({tag, "_frame"}, f, exp);
    chk({tag, "_done"}, {36'b0, done, busy, tx_valid, tx_bit}, {36'b0, 4'b1000});
  endtask

  initial begin
    // 1: reset with send high
    rst = 1'b1; send = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {36'b0, busy, tx_valid, tx_bit, done}, 40'd0);
    #1 send = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {36'b0, busy, tx_valid, tx_bit, done}, 40'd0);

    // 2: basic frame, 0x12+0x34+0x56 = 0x9C
    pos_x = 8'h12; pos_y = 8'h34; pos_z = 8'h56;
    fork
      pulse_send();
      collect("t2", 40'hA5_12_34_56_9C, waited);
    join
    @(negedge clk);
    chk("t2_idle_after", {37'b0, busy, tx_valid, done}, 40'd0);

    // 3: checksum truncation, 0x2FD -> 0xFD
    pos_x = 8'hFF; pos_y = 8'hFF; pos_z = 8'hFF;
    fork
      pulse_send();
      collect("t3", 40'hA5_FF_FF_FF_FD, waited);
    join

    // 4: snapshot isolation and ignored mid-frame send; 0x0F+0xF0+0x33 = 0x32
    pos_x = 8'h0F; pos_y = 8'hF0; pos_z = 8'h33;
    fork
      begin
        pulse_send();
        repeat (18) @(posedge clk);
        #1 pos_x = 8'h00; send = 1'b1;
        @(posedge clk); #1 send = 1'b0;
      end
      collect("t4", 40'hA5_0F_F0_33_32, waited);
    join
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid || done) seen++;
    end
    chk("t4_no_second", seen, 40'd0);

    // 5: send held high -> back-to-back frames, one done cycle between; 1+2+3 = 6
    pos_x = 8'h01; pos_y = 8'h02; pos_z = 8'h03;
    @(posedge clk); #1 send = 1'b1;
    collect("t5a", 40'hA5_01_02_03_06, waited);
    collect("t5b", 40'hA5_01_02_03_06, waited);
    chk("t5_gap", waited, 40'd0);
    collect("t5c", 40'hA5_01_02_03_06, waited);
    chk("t5_gap2", waited, 40'd0);
    send = 1'b0;
    @(negedge clk);
    chk("t5_stop", {38'b0, busy, tx_valid}, 40'd0);

    // 6: reset during ZW aborts; then a clean frame; 0x80+0x40+0x3C = 0xFC
    pos_x = 8'hAA; pos_y = 8'hBB; pos_z = 8'hCC;
    pulse_send();
    repeat (27) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_abort", {36'b0, busy, tx_valid, tx_bit, done}, 40'd0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid || done || busy) seen++;
    end
    chk("t6_no_done", seen, 40'd0);
    pos_x = 8'h80; pos_y = 8'h40; pos_z = 8'h3C;
    fork
      pulse_send();
      collect("t6", 40'hA5_80_40_3C_FC, waited);
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
